// File: rtl/lives_pkg.sv
// lives_pkg
// Shared types and constants for the lives controller slice.
//   state_e       : controller state encoding (IDLE=0, PLAY=1, INVULN=2, OVER=3)
//   LIVES_W       : width of the lives count bus
//   Def*          : default parameter values for lives_controller
//   max_u()       : helper used to size the shared frame counter
package lives_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StPlay   = 2'd1,
        StInvuln = 2'd2,
        StOver   = 2'd3
    } state_e;

    localparam int unsigned LIVES_W = 10;

    localparam int unsigned DefInitLives   = 4;
    localparam int unsigned DefInvulnFrames = 120;
    localparam int unsigned DefBlinkHalf   = 8;
    localparam int unsigned DefOverFrames  = 180;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/frame_down_counter.sv
// frame_down_counter
// Loadable down counter advanced by frame ticks; holds at zero.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (count -> 0)
//   load_i     : load load_val_i (has priority over tick_i)
//   load_val_i : value to load
//   tick_i     : decrement by one (saturates at zero)
//   count_o    : current count
//   zero_o     : count is zero
//   expire_o   : this tick brings the count to zero (or it already was zero)
module frame_down_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             tick_i,
    output logic [Width-1:0] count_o,
    output logic             zero_o,
    output logic             expire_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign zero_o   = (count_q == '0);
    // A zero-loaded counter expires on its first tick, so a zero-length window still exits.
    assign expire_o = tick_i && (count_q <= Width'(1));

endmodule

// File: rtl/lives_controller.sv
// lives_controller
// Player life-state sequencer: owns the lives count and title/run flag, runs the
// post-hit invulnerability/blink window and the game-over hold.
//   Pclk       : 25 MHz pixel clock
//   reset      : synchronous active-high reset
//   frame_tick : one pulse per video frame
//   start_req  : start button pulse
//   hit        : player struck pulse
//   life_up    : extra life pulse
//   lives      : current life count (0..INIT_LIVES)
//   start      : 1 in title/idle, 0 while a game (or game-over hold) is running
//   game_over  : high in OVER
//   invuln     : high in INVULN
//   player_vis : player sprite enable, blinks during INVULN
//   respawn    : one-cycle pulse on the first INVULN cycle
module lives_controller
    import lives_pkg::*;
#(
    parameter int unsigned INIT_LIVES    = DefInitLives,
    parameter int unsigned INVULN_FRAMES = DefInvulnFrames,
    parameter int unsigned BLINK_HALF    = DefBlinkHalf,
    parameter int unsigned OVER_FRAMES   = DefOverFrames
) (
    input  logic               Pclk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_req,
    input  logic               hit,
    input  logic               life_up,
    output logic [LIVES_W-1:0] lives,
    output logic               start,
    output logic               game_over,
    output logic               invuln,
    output logic               player_vis,
    output logic               respawn
);

    // One frame counter is shared by INVULN and OVER, so size it for the longer window.
    localparam int unsigned FrameW = $clog2(max_u(INVULN_FRAMES, OVER_FRAMES)) + 1;
    localparam int unsigned BlinkW = $clog2(BLINK_HALF) + 1;

    localparam logic [LIVES_W-1:0] InitLives  = LIVES_W'(INIT_LIVES);
    localparam logic [LIVES_W-1:0] OneLife    = LIVES_W'(1);
    localparam logic [FrameW-1:0]  InvulnLoad = FrameW'(INVULN_FRAMES);
    localparam logic [FrameW-1:0]  OverLoad   = FrameW'(OVER_FRAMES);
    localparam logic [BlinkW-1:0]  BlinkLoad  = BlinkW'(BLINK_HALF);

    state_e             state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               start_q, start_d;
    logic               game_over_q, game_over_d;
    logic               invuln_q, invuln_d;
    logic               vis_q, vis_d;
    logic               respawn_q, respawn_d;

    logic              frame_load, frame_tick_en, frame_zero, frame_expire;
    logic [FrameW-1:0] frame_val, frame_count;
    logic              blink_load, blink_tick_en, blink_zero, blink_expire;
    logic [BlinkW-1:0] blink_count;

    // Counters only see ticks in the states that own them; ticks elsewhere are not counted.
    assign frame_tick_en = frame_tick && ((state_q == StInvuln) || (state_q == StOver));
    assign blink_tick_en = frame_tick && (state_q == StInvuln);

    frame_down_counter #(
        .Width (FrameW)
    ) u_frame_cnt (
        .clk_i      (Pclk),
        .rst_i      (reset),
        .load_i     (frame_load),
        .load_val_i (frame_val),
        .tick_i     (frame_tick_en),
        .count_o    (frame_count),
        .zero_o     (frame_zero),
        .expire_o   (frame_expire)
    );

    frame_down_counter #(
        .Width (BlinkW)
    ) u_blink_cnt (
        .clk_i      (Pclk),
        .rst_i      (reset),
        .load_i     (blink_load),
        .load_val_i (BlinkLoad),
        .tick_i     (blink_tick_en),
        .count_o    (blink_count),
        .zero_o     (blink_zero),
        .expire_o   (blink_expire)
    );

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        vis_d      = vis_q;
        respawn_d  = 1'b0;
        frame_load = 1'b0;
        frame_val  = InvulnLoad;
        blink_load = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_req) begin
                    state_d = StPlay;
                    lives_d = InitLives;
                end
            end
            StPlay: begin
                // A hit wins over a same-cycle life_up, which is dropped.
                if (hit) begin
                    frame_load = 1'b1;
                    if (lives_q <= OneLife) begin
                        state_d   = StOver;
                        lives_d   = '0;
                        frame_val = OverLoad;
                    end else begin
                        state_d    = StInvuln;
                        lives_d    = lives_q - OneLife;
                        respawn_d  = 1'b1;
                        frame_val  = InvulnLoad;
                        blink_load = 1'b1;
                        vis_d      = 1'b0;
                    end
                end else if (life_up && (lives_q < InitLives)) begin
                    lives_d = lives_q + OneLife;
                end
            end
            StInvuln: begin
                if (life_up && (lives_q < InitLives)) begin
                    lives_d = lives_q + OneLife;
                end
                if (frame_expire) begin
                    state_d = StPlay;
                    vis_d   = 1'b1;
                end else if (blink_expire) begin
                    blink_load = 1'b1;
                    vis_d      = ~vis_q;
                end
            end
            StOver: begin
                if (start_req) begin
                    state_d = StPlay;
                    lives_d = InitLives;
                end else if (frame_expire) begin
                    state_d = StIdle;
                    lives_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                lives_d = '0;
                vis_d   = 1'b1;
            end
        endcase

        start_d     = (state_d == StIdle);
        game_over_d = (state_d == StOver);
        invuln_d    = (state_d == StInvuln);
    end

    always_ff @(posedge Pclk) begin
        if (reset) begin
            state_q     <= StIdle;
            lives_q     <= '0;
            start_q     <= 1'b1;
            game_over_q <= 1'b0;
            invuln_q    <= 1'b0;
            vis_q       <= 1'b1;
            respawn_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            start_q     <= start_d;
            game_over_q <= game_over_d;
            invuln_q    <= invuln_d;
            vis_q       <= vis_d;
            respawn_q   <= respawn_d;
        end
    end

    assign lives      = lives_q;
    assign start      = start_q;
    assign game_over  = game_over_q;
    assign invuln     = invuln_q;
    assign player_vis = vis_q;
    assign respawn    = respawn_q;

    // Counter status flags are kept for debug visibility only.
    logic unused_ok;
    assign unused_ok = ^{frame_zero, frame_count, blink_zero, blink_count};

endmodule

// File: tb/tb_lives_controller.sv
module tb_lives_controller;

    logic       Pclk = 1'b0;
    logic       reset;
    logic       frame_tick, start_req, hit, life_up;
    logic [9:0] lives;
    logic       start, game_over, invuln, player_vis, respawn;

    int compared   = 0;
    int mismatched = 0;

    always #5 Pclk = ~Pclk;

    lives_controller dut (
        .Pclk       (Pclk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start_req  (start_req),
        .hit        (hit),
        .life_up    (life_up),
        .lives      (lives),
        .start      (start),
        .game_over  (game_over),
        .invuln     (invuln),
        .player_vis (player_vis),
        .respawn    (respawn)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs from a negedge; returns at the next negedge.
    task automatic step(input logic s, input logic h, input logic l, input logic f);
        start_req  = s;
        hit        = h;
        life_up    = l;
        frame_tick = f;
        @(negedge Pclk);
        start_req  = 1'b0;
        hit        = 1'b0;
        life_up    = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".lives"}, 32'(lives), 0);
        check({tag, ".start"}, 32'(start), 1);
        check({tag, ".game_over"}, 32'(game_over), 0);
        check({tag, ".invuln"}, 32'(invuln), 0);
        check({tag, ".player_vis"}, 32'(player_vis), 1);
        check({tag, ".respawn"}, 32'(respawn), 0);
    endtask

    initial begin
        reset = 1'b1;
        frame_tick = 1'b0; start_req = 1'b0; hit = 1'b0; life_up = 1'b0;
        @(negedge Pclk);
        @(negedge Pclk);
        reset = 1'b0;
        check_reset_vals("reset");

        // IDLE ignores hit and life_up
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("idle_ignore.lives", 32'(lives), 0);
        check("idle_ignore.start", 32'(start), 1);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("start.lives", 32'(lives), 4);
        check("start.start", 32'(start), 0);

        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("lifeup_sat.lives", 32'(lives), 4);

        // First hit: 4 -> 3, INVULN entered
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("hit1.lives", 32'(lives), 3);
        check("hit1.respawn", 32'(respawn), 1);
        check("hit1.invuln", 32'(invuln), 1);
        check("hit1.vis", 32'(player_vis), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("respawn_one_cycle", 32'(respawn), 0);
        check("inv_start_ignored.lives", 32'(lives), 3);
        check("inv_start_ignored.invuln", 32'(invuln), 1);

        ticks(7);
        check("blink.t7", 32'(player_vis), 0);
        ticks(1);
        check("blink.t8", 32'(player_vis), 1);
        ticks(8);
        check("blink.t16", 32'(player_vis), 0);
        ticks(33);
        // tick 50 carries a hit: ignored in INVULN
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("inv_hit.lives", 32'(lives), 3);
        check("inv_hit.respawn", 32'(respawn), 0);
        check("inv_hit.vis_t50", 32'(player_vis), 0);
        // tick 51 with life_up: both applied
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("inv_lifeup.lives", 32'(lives), 4);
        ticks(68);
        check("inv_t119.invuln", 32'(invuln), 1);
        ticks(1);
        check("inv_t120.invuln", 32'(invuln), 0);
        check("inv_t120.vis", 32'(player_vis), 1);
        check("inv_t120.lives", 32'(lives), 4);

        // 4 -> 3
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("hit2.lives", 32'(lives), 3);
        ticks(120);
        check("hit2_exit.invuln", 32'(invuln), 0);
        // hit + life_up together at 3 -> 2
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("hit_lifeup.lives", 32'(lives), 2);
        check("hit_lifeup.respawn", 32'(respawn), 1);
        ticks(120);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("hit4.lives", 32'(lives), 1);
        ticks(120);
        check("hit4_exit.invuln", 32'(invuln), 0);
        // Fatal hit with a coincident frame tick
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("fatal.lives", 32'(lives), 0);
        check("fatal.game_over", 32'(game_over), 1);
        check("fatal.respawn", 32'(respawn), 0);
        check("fatal.invuln", 32'(invuln), 0);
        check("fatal.start", 32'(start), 0);
        ticks(179);
        check("over_t179.game_over", 32'(game_over), 1);
        ticks(1);
        check("over_t180.game_over", 32'(game_over), 0);
        check("over_t180.start", 32'(start), 1);
        check("over_t180.lives", 32'(lives), 0);

        // Back to OVER, then start_req at OVER tick 10
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            ticks(120);
        end
        check("replay.lives", 32'(lives), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("replay_fatal.game_over", 32'(game_over), 1);
        ticks(10);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("over_restart.lives", 32'(lives), 4);
        check("over_restart.game_over", 32'(game_over), 0);
        check("over_restart.start", 32'(start), 0);

        // Reset during INVULN at lives=2
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(120);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_reset.lives", 32'(lives), 2);
        check("pre_reset.invuln", 32'(invuln), 1);
        ticks(5);
        reset = 1'b1;
        @(negedge Pclk);
        reset = 1'b0;
        check_reset_vals("midreset");
        // Must be IDLE: hit ignored, start_req starts a game
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("post_reset_hit.lives", 32'(lives), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("post_reset_start.lives", 32'(lives), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lives_controller.md
# lives_controller

Sequencing controller for the on-screen lives display and player life state. It owns the `lives` count and `start` flag consumed by the lives icon sprite block. It reacts to player-hit and extra-life events, runs a frame-based invulnerability/blink window after each hit, and sequences game-over back to the title state. It sits between the game logic (collision, score) and the sprite and renderer layer, all in the 25 MHz pixel clock domain.

## Interface
- `INIT_LIVES`, 4: value loaded into `lives` at game start; the display shows `lives-1` icons, so 4 means three icons.
- `INVULN_FRAMES`, 120: frames of hit immunity after a non-fatal hit.
- `BLINK_HALF`, 8: frames per blink half-period during invulnerability.
- `OVER_FRAMES`, 180: frames the game-over state holds before returning to idle.

Ports:
- `Pclk`  in  1  25 MHz pixel clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse, once per video frame.
- `start_req`  in  1  one-cycle pulse: player pressed start.
- `hit`  in  1  one-cycle pulse: player struck.
- `life_up`  in  1  one-cycle pulse: award one life.
- `lives`  out  10  current life count, 0..INIT_LIVES.
- `start`  out  1  1 = title/idle screen, 0 = game running (includes game-over hold).
- `game_over`  out  1  high throughout the OVER state.
- `invuln`  out  1  high throughout the INVULN state.
- `player_vis`  out  1  player sprite enable; toggles during INVULN, otherwise 1.
- `respawn`  out  1  one-cycle pulse on each non-fatal hit.

## Operation
- States: IDLE, PLAY, INVULN, OVER.
- Reset values: state=IDLE, `lives`=0, `start`=1, `game_over`=0, `invuln`=0, `player_vis`=1, `respawn`=0, all counters 0.
- IDLE:
  - `start_req` -> PLAY, `lives`=INIT_LIVES, `start`=0.
  - `hit` and `life_up` are ignored.
- PLAY, on `hit`:
  - `lives`==1 -> `lives`=0, OVER, `game_over`=1, frame counter=OVER_FRAMES.
  - Otherwise `lives`-=1, INVULN, `respawn` pulses, frame counter=INVULN_FRAMES, blink counter=BLINK_HALF, `player_vis`=0.
- PLAY/INVULN, on `life_up`: `lives`+=1, saturating at INIT_LIVES.
- PLAY/INVULN, `start_req`: ignored.
- INVULN:
  - `hit` is ignored.
  - Each `frame_tick` decrements the frame counter and the blink counter.
  - When the blink counter reaches 0: reload it to BLINK_HALF and toggle `player_vis`.
  - When the frame counter reaches 0 -> PLAY, `invuln`=0, `player_vis`=1.
- OVER:
  - Each `frame_tick` decrements the frame counter; at 0 -> IDLE, `game_over`=0, `start`=1, `lives`=0.
  - `start_req` in OVER -> PLAY immediately with `lives`=INIT_LIVES and `game_over`=0.
- Simultaneous events:
  - `hit` with `life_up` in PLAY: the hit is applied and `life_up` is dropped.
  - `hit` with `frame_tick` in PLAY: the hit is applied.
  - `life_up` with `frame_tick` in INVULN: both are applied.
- Arithmetic:
  - `lives` never underflows below 0 or exceeds INIT_LIVES.
  - Counters are sized with `$clog2` of their parameter plus 1; zero-valued parameters mean the state exits on the first `frame_tick`.
  - No ticks are lost or double-counted at state entry.

## Timing
- All outputs are registered; each reacts on the `Pclk` edge after the input pulse is sampled, a latency of 1 cycle.
- `respawn` is high for exactly 1 cycle, coincident with the first INVULN cycle.
- INVULN lasts exactly INVULN_FRAMES `frame_tick` pulses. OVER lasts OVER_FRAMES pulses unless `start_req` arrives first.
- `reset` asserted mid-game: the next cycle shows reset values, and no `respawn` or `game_over` pulse is emitted.
- Input pulses are held for 1 cycle by producers; a level held high is treated as a new event each cycle, except for the ignore rules above.

## Structure
- Package `lives_pkg`:
  - state enum (2-bit: IDLE=0, PLAY=1, INVULN=2, OVER=3).
  - LIVES_W=10.
  - default parameter constants.
- Sub-module `frame_down_counter`:
  - parameterised width, load/tick/zero flag.
  - instantiated twice: one frame counter shared by INVULN/OVER, one blink counter.
- FSM and `lives` register live in the top module.

## Test plan
- Reset, then `start_req` -> next cycle `lives`=4, `start`=0; `hit` -> `lives`=3, `respawn` 1 cycle, `invuln`=1.
- In INVULN (INVULN_FRAMES=120, BLINK_HALF=8): `player_vis` toggles every 8 ticks; a `hit` at tick 50 leaves `lives`=3; after tick 120 the block is in PLAY and `player_vis`=1.
- Three non-fatal hits separated by invulnerability -> `lives` 4->3->2->1; the fourth hit gives `lives`=0 and `game_over`=1; after 180 ticks `start`=1 and `game_over`=0.
- `life_up` at `lives`=4 -> stays 4; `hit` and `life_up` in the same cycle at `lives`=3 -> 2.
- `start_req` at OVER tick 10 -> PLAY, `lives`=4, `game_over`=0 next cycle.
- `reset` during INVULN with `lives`=2 -> next cycle all outputs at reset values, state IDLE.
